// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, stall/flush generation and the
// multi-cycle mult/div occupancy sequencer that guards HI/LO readers.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       branch_D,
    input  logic       reg_jump_D,
    input  logic       jump_D,
    input  logic       pc_src_D,
    input  logic       md_op_D,
    input  logic       hilo_rd_D,
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic [4:0] rf_wa_E,
    input  logic       rf_we_E,
    input  logic       dm2reg_E,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic [4:0] rf_wa_M,
    input  logic       rf_we_M,
    input  logic       dm2reg_M,
    input  logic [4:0] rf_wa_WB,
    input  logic       rf_we_WB,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic       fwd_a_D,
    output logic       fwd_b_D,
    output logic [1:0] fwd_a_E,
    output logic [1:0] fwd_b_E,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_t  state;
    md_state_t  state_next;
    logic [5:0] cnt;
    logic [5:0] cnt_next;

    logic m_writes;
    logic wb_writes;
    logic lw_stall;
    logic br_stall;
    logic jr_stall;
    logic md_stall;
    logic e_hits_rs;
    logic e_hits_rt;
    logic m_load_hits_rs;
    logic m_load_hits_rt;
    logic hazard;

    // Register 0 is hardwired, so a write to it is never a real producer.
    assign m_writes  = rf_we_M  && (rf_wa_M  != 5'd0);
    assign wb_writes = rf_we_WB && (rf_wa_WB != 5'd0);

    always_comb begin
        fwd_a_E = 2'b00;
        fwd_b_E = 2'b00;
        if (m_writes && (rf_wa_M == rs_E)) begin
            fwd_a_E = 2'b10;
        end else if (wb_writes && (rf_wa_WB == rs_E)) begin
            fwd_a_E = 2'b01;
        end
        if (m_writes && (rf_wa_M == rt_E)) begin
            fwd_b_E = 2'b10;
        end else if (wb_writes && (rf_wa_WB == rt_E)) begin
            fwd_b_E = 2'b01;
        end
    end

    assign fwd_a_D = m_writes && (rf_wa_M == rs_D);
    assign fwd_b_D = m_writes && (rf_wa_M == rt_D);

    // Producers a decode-stage comparator cannot yet reach via forwarding.
    assign e_hits_rs      = rf_we_E  && (rf_wa_E != 5'd0) && (rf_wa_E == rs_D);
    assign e_hits_rt      = rf_we_E  && (rf_wa_E != 5'd0) && (rf_wa_E == rt_D);
    assign m_load_hits_rs = dm2reg_M && (rf_wa_M != 5'd0) && (rf_wa_M == rs_D);
    assign m_load_hits_rt = dm2reg_M && (rf_wa_M != 5'd0) && (rf_wa_M == rt_D);

    assign lw_stall = dm2reg_E && (rf_wa_E != 5'd0) &&
                      ((rf_wa_E == rs_D) || (rf_wa_E == rt_D));
    assign br_stall = branch_D &&
                      (e_hits_rs || e_hits_rt || m_load_hits_rs || m_load_hits_rt);
    assign jr_stall = reg_jump_D && (e_hits_rs || m_load_hits_rs);
    assign md_stall = (md_op_D || hilo_rd_D) && ((state == MUL) || (state == DIV));

    assign hazard  = lw_stall | br_stall | jr_stall | md_stall;
    assign stall_F = hazard;
    assign stall_D = hazard;
    assign flush_E = hazard;
    // A stalled redirect is retried next cycle, so it must not flush yet.
    assign flush_D = (pc_src_D | jump_D | reg_jump_D) && !hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Start requests are only honoured from IDLE; DONE always drains first.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (md_start_E) begin
                    if (md_is_div_E) begin
                        state_next = DIV;
                        cnt_next   = DIV_LOAD;
                    end else begin
                        state_next = MUL;
                        cnt_next   = MUL_LOAD;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt == 6'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 6'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 6'd0;
            end
        endcase
    end

    assign md_busy = (state == MUL) || (state == DIV);
    assign md_done = (state == DONE);

endmodule
